occ_rom_responder: RTL

- Responder end of the 4-channel Occ fetch protocol: accepts `ce`/`addr` requests from up to four accelerator paths.
- Arbitrates them round-robin onto one single-port synchronous Occ ROM.
- Returns each read word on the requesting channel with a one-cycle `done` pulse.
- Sits between the accelerator initiators and the Occ ROM macro, fully pipelined: one ROM issue per cycle.

---
 rtl/occ_rom_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/occ_rom_responder.sv
// Four-channel Occ fetch responder: round-robin arbitration of per-channel requests
// onto a single-port synchronous ROM, with responses routed back per channel.
module occ_rom_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              storage_ce_1,
    input  logic              storage_ce_2,
    input  logic              storage_ce_3,
    input  logic              storage_ce_4,
    input  logic [ADDR_W-1:0] storage_addr_1,
    input  logic [ADDR_W-1:0] storage_addr_2,
    input  logic [ADDR_W-1:0] storage_addr_3,
    input  logic [ADDR_W-1:0] storage_addr_4,
    output logic [DATA_W-1:0] data_to_alu_1,
    output logic [DATA_W-1:0] data_to_alu_2,
    output logic [DATA_W-1:0] data_to_alu_3,
    output logic [DATA_W-1:0] data_to_alu_4,
    output logic              done_1,
    output logic              done_2,
    output logic              done_3,
    output logic              done_4,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              busy_o,
    output logic              err_overrun_o
);
    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    logic [N_CH-1:0]    ce;
    logic [ADDR_W-1:0]  req_addr [N_CH];

    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    outstanding;
    logic [N_CH-1:0]    done_q;
    logic [ADDR_W-1:0]  addr_q [N_CH];
    logic [DATA_W-1:0]  data_q [N_CH];
    logic [CH_W-1:0]    rr_ptr;
    logic               err_q;

    logic [ROM_LAT-1:0] pipe_vld;
    logic [CH_W-1:0]    pipe_ch [ROM_LAT];

    logic               grant_vld;
    logic [CH_W-1:0]    grant_ch;
    logic [CH_W-1:0]    cand;
    logic               resp_vld;
    logic [CH_W-1:0]    resp_ch;

    assign ce          = {storage_ce_4, storage_ce_3, storage_ce_2, storage_ce_1};
    assign req_addr[0] = storage_addr_1;
    assign req_addr[1] = storage_addr_2;
    assign req_addr[2] = storage_addr_3;
    assign req_addr[3] = storage_addr_4;

    // Round-robin pick: scan farthest offset first so the nearest pending channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = rr_ptr;
        cand      = rr_ptr;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = rr_ptr + CH_W'(i);
            if (pending[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    assign rom_ce_o   = grant_vld;
    assign rom_addr_o = grant_vld ? addr_q[grant_ch] : '0;

    assign resp_vld = pipe_vld[ROM_LAT-1];
    assign resp_ch  = pipe_ch[ROM_LAT-1];

    // Channel state: acceptance, grant retirement, response capture and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
            done_q      <= '0;
            rr_ptr      <= '0;
            err_q       <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                addr_q[c] <= '0;
                data_q[c] <= '0;
            end
        end else begin
            done_q <= '0;
            if (resp_vld) begin
                done_q[resp_ch]      <= 1'b1;
                data_q[resp_ch]      <= rom_data_i;
                outstanding[resp_ch] <= 1'b0;
            end
            if (grant_vld) begin
                pending[grant_ch] <= 1'b0;
                rr_ptr            <= grant_ch + CH_W'(1);
            end
            // A request on a busy channel is dropped; only the sticky flag records it.
            for (int c = 0; c < N_CH; c++) begin
                if (ce[c]) begin
                    if (outstanding[c]) begin
                        err_q <= 1'b1;
                    end else begin
                        pending[c]     <= 1'b1;
                        outstanding[c] <= 1'b1;
                        addr_q[c]      <= req_addr[c];
                    end
                end
            end
        end
    end

    // In-flight tracker aligned with ROM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int s = 0; s < ROM_LAT; s++) begin
                pipe_ch[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= grant_vld;
            pipe_ch[0]  <= grant_ch;
            for (int s = 1; s < ROM_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_ch[s]  <= pipe_ch[s-1];
            end
        end
    end

    assign data_to_alu_1 = data_q[0];
    assign data_to_alu_2 = data_q[1];
    assign data_to_alu_3 = data_q[2];
    assign data_to_alu_4 = data_q[3];
    assign done_1        = done_q[0];
    assign done_2        = done_q[1];
    assign done_3        = done_q[2];
    assign done_4        = done_q[3];
    assign busy_o        = |outstanding;
    assign err_overrun_o = err_q;

endmodule
